// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial MSB-first magnitude comparator: FSM states,
// running decision and the registered result flags.
package serial_cmp_pkg;

   localparam int CMP_MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // EQUAL is the all-zero encoding so a cleared decision register reads EQUAL.
   typedef enum logic [1:0] {
      EQUAL   = 2'd0,
      GREATER = 2'd1,
      LESS    = 2'd2
   } decision_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
      logic ne;
   } flags_t;

   function automatic flags_t decision_to_flags(input decision_t dec);
      flags_t f;
      f = '0;
      case (dec)
         GREATER: f.gt = 1'b1;
         LESS:    f.lt = 1'b1;
         default: f.eq = 1'b1;
      endcase
      f.ne = ~f.eq;
      return f;
   endfunction

endpackage

// File: rtl/onebit_cmp_cell.sv
// Combinational 1-bit magnitude compare cell; exactly one output is high.
module onebit_cmp_cell (
   input  logic x,
   input  logic y,
   output logic gt,
   output logic eq,
   output logic lt
);

   assign gt = x & ~y;
   assign eq = ~(x ^ y);
   assign lt = ~x & y;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with done pulse and held flags.
// Define SERIAL_CMP_SIGNED_EN for a two's complement compare.
module serial_magnitude_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             ne
);

   localparam int             CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > CMP_MAX_WIDTH) begin : g_width_check
      $error("serial_magnitude_comparator: WIDTH must be in 2..%0d", CMP_MAX_WIDTH);
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [CNT_W-1:0] r_cnt;
   decision_t        r_dec;
   logic             r_busy;
   logic             r_done;
   flags_t           r_flags;

   logic      w_cell_gt;
   logic      w_cell_eq;
   logic      w_cell_lt;
   logic      w_invert;
   logic      w_bit_gt;
   logic      w_bit_lt;
   logic      w_finish;
   decision_t w_dec_next;

   onebit_cmp_cell u_cell (
      .x  (r_sa[WIDTH-1]),
      .y  (r_sb[WIDTH-1]),
      .gt (w_cell_gt),
      .eq (w_cell_eq),
      .lt (w_cell_lt)
   );

   // A two's complement sign bit weighs negatively, so only a first
   // difference found on the very first shift flips the outcome.
`ifdef SERIAL_CMP_SIGNED_EN
   assign w_invert = (r_cnt == CNT_MAX);
`else
   assign w_invert = 1'b0;
`endif

   assign w_bit_gt = w_invert ? w_cell_lt : w_cell_gt;
   assign w_bit_lt = w_invert ? w_cell_gt : w_cell_lt;
   assign w_finish = (EARLY_EXIT && !w_cell_eq) || (r_cnt == '0);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_dec_next = r_dec;
      if (r_dec == EQUAL) begin
         if (w_bit_gt)      w_dec_next = GREATER;
         else if (w_bit_lt) w_dec_next = LESS;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the operand shift registers are reset as well; the cost is small and state is fully defined after reset.
         r_state <= IDLE;
         r_sa    <= '0;
         r_sb    <= '0;
         r_cnt   <= '0;
         r_dec   <= EQUAL;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_flags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_cnt   <= CNT_MAX;
                  r_dec   <= EQUAL;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end

            SHIFT: begin
               r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
               r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
               r_dec <= w_dec_next;
               if (w_finish) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_flags <= decision_to_flags(w_dec_next);
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign gt   = r_flags.gt;
   assign eq   = r_flags.eq;
   assign lt   = r_flags.lt;
   assign ne   = r_flags.ne;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomised and directed bench for serial_magnitude_comparator; instance 0
// uses early exit, instance 1 the fixed-latency scan.
module tb_serial_magnitude_comparator;

   localparam int W          = 8;
   localparam int LAT_BUDGET = 3 * W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   start_v = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [1:0]   busy_v, done_v, gt_v, eq_v, lt_v, ne_v;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]),
      .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .ne(ne_v[0])
   );

   serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fx (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]),
      .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .ne(ne_v[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] flags_of(input int idx);
      return {gt_v[idx], eq_v[idx], lt_v[idx], ne_v[idx]};
   endfunction

   // Reference result as {gt, eq, lt, ne} straight from integer comparison.
   function automatic logic [3:0] model_flags(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERIAL_CMP_SIGNED_EN
      if ($signed(av) > $signed(bv)) return 4'b1001;
      if ($signed(av) < $signed(bv)) return 4'b0011;
`else
      if (av > bv) return 4'b1001;
      if (av < bv) return 4'b0011;
`endif
      return 4'b0100;
   endfunction

   // Edges from the accepting edge to the edge at which done is seen high.
   function automatic int model_lat(input bit ee, input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W-1:0] d;
      d = av ^ bv;
      if (!ee || d == '0) return W + 1;
      for (int i = W - 1; i >= 0; i--)
         if (d[i]) return (W - i) + 1;
      return W + 1;
   endfunction

   // One compare on instance idx; optionally pokes a second start (pa/pb) so it
   // is sampled at edge k+poke_at, which must be ignored.
   task automatic run_compare(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input int poke_at, input logic [W-1:0] pa, input logic [W-1:0] pb,
                              input string tag);
      logic [3:0] exp_f;
      int         exp_lat;
      int         m;
      int         busy_cnt;
      bit         seen;
      exp_f    = model_flags(av, bv);
      exp_lat  = model_lat(idx == 0, av, bv);
      m        = 0;
      busy_cnt = 0;
      seen     = 1'b0;
      @(negedge clk);
      a = av;
      b = bv;
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      while (!seen && m < LAT_BUDGET) begin
         if (done_v[idx]) begin
            seen = 1'b1;
         end else begin
            if (busy_v[idx]) busy_cnt++;
            if (poke_at != 0 && m + 1 == poke_at) begin
               a = pa;
               b = pb;
               start_v[idx] = 1'b1;
            end else begin
               start_v[idx] = 1'b0;
            end
            @(negedge clk);
            m++;
         end
      end
      start_v[idx] = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_latency"}, 32'(m + 1), 32'(exp_lat));
         check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
         check({tag, "_busy_at_done"}, 32'(busy_v[idx]), 32'd0);
         check({tag, "_flags"}, 32'(flags_of(idx)), 32'(exp_f));
         @(negedge clk);
         check({tag, "_pulse_width"}, 32'(done_v[idx]), 32'd0);
         check({tag, "_flag_hold"}, 32'(flags_of(idx)), 32'(exp_f));
      end
   endtask

   initial begin
      int         dones;
      int         last_cyc;
      int         cyc;
      bit         prev_done;
      bit         hold_bad;
      logic [3:0] exp_cur;
      logic [3:0] exp_hold;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_busy", 32'(busy_v[i]), 32'd0);
         check("reset_done", 32'(done_v[i]), 32'd0);
         check("reset_flags", 32'(flags_of(i)), 32'd0);
      end
      rst = 1'b0;

      // Directed cases from the WIDTH=8 plan.
      run_compare(0, 8'h5A, 8'h5A, 0, '0, '0, "equal_ee");
      run_compare(1, 8'h5A, 8'h5A, 0, '0, '0, "equal_fx");
      run_compare(0, 8'h80, 8'h7F, 0, '0, '0, "msb_exit");
      run_compare(0, 8'h12, 8'h13, 0, '0, '0, "lsb_diff");
      run_compare(1, 8'hF0, 8'h0F, 0, '0, '0, "fixed_lat");
      run_compare(0, 8'h01, 8'h02, 3, 8'hFF, 8'h00, "busy_protect");
      dones = 0;
      for (int n = 0; n < W + 4; n++) begin
         @(negedge clk);
         if (done_v[0]) dones++;
      end
      check("busy_protect_extra_done", 32'(dones), 32'd0);

      // Mid-compare reset: rst sampled at edge k+4 of a slow compare.
      @(negedge clk);
      a = 8'h40;
      b = 8'h41;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("midrst_busy", 32'(busy_v[i]), 32'd0);
         check("midrst_done", 32'(done_v[i]), 32'd0);
         check("midrst_flags", 32'(flags_of(i)), 32'd0);
      end
      rst = 1'b0;
      dones = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done_v[0]) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);
      run_compare(0, 8'h03, 8'h03, 0, '0, '0, "after_rst");

      // Random compares, biased towards single-bit and zero differences.
      for (int t = 0; t < 40; t++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         case ($urandom_range(2, 0))
            0:       rb = W'($urandom);
            1:       rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
            default: rb = ra;
         endcase
         run_compare(t % 2, ra, rb, 0, '0, '0, "rand");
      end

      // Back-to-back: start held high on the fixed-latency instance.
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      exp_cur    = model_flags(a, b);
      exp_hold   = '0;
      start_v[1] = 1'b1;
      dones      = 0;
      last_cyc   = 0;
      cyc        = 0;
      prev_done  = 1'b0;
      hold_bad   = 1'b0;
      while (dones < 4 && cyc < 4 * (W + 2) + 2 * W) begin
         @(negedge clk);
         cyc++;
         if (prev_done) check("b2b_pulse_width", 32'(done_v[1]), 32'd0);
         prev_done = done_v[1];
         if (done_v[1]) begin
            check("b2b_flags", 32'(flags_of(1)), 32'(exp_cur));
            if (dones > 0) check("b2b_period", 32'(cyc - last_cyc), 32'(W + 2));
            last_cyc = cyc;
            dones++;
            exp_hold = exp_cur;
            a = W'($urandom);
            b = W'($urandom);
            exp_cur = model_flags(a, b);
         end else if (dones > 0 && flags_of(1) !== exp_hold) begin
            hold_bad = 1'b1;
         end
      end
      start_v[1] = 1'b0;
      check("b2b_done_count", 32'(dones), 32'd4);
      check("b2b_flag_hold", 32'(hold_bad), 32'd0);
      repeat (W + 4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
